// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-way arbiter (loader/data/fetch) for one single-port synchronous memory
// Boot grants only the loader; run grants data over fetch with a bounded data run, and tags reads for return routing.
`ifndef ADDR_W
`define ADDR_W 10
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module mem_port_arbiter #(
  parameter int LOAD_LATENCY = 1,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ld_req,
  input  logic [`ADDR_W-1:0]   ld_addr,
  input  logic [`DATA_W-1:0]   ld_wdata,
  input  logic                 boot_done,
  output logic                 ld_gnt,
  input  logic                 d_req,
  input  logic [`ADDR_W-1:0]   d_addr,
  input  logic [`DATA_W-1:0]   d_wdata,
  input  logic [`DATA_W/8-1:0] d_we,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [`DATA_W-1:0]   d_rdata,
  input  logic                 i_req,
  input  logic [`ADDR_W-1:0]   i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [`DATA_W-1:0]   i_rdata,
  output logic                 core_run,
  output logic [`ADDR_W-1:0]   mem_addr,
  output logic [`DATA_W-1:0]   mem_wdata,
  output logic [`DATA_W/8-1:0] mem_we,
  input  logic [`DATA_W-1:0]   mem_rdata
);

  localparam int CW = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic {BOOT, RUN} state_t;
  state_t state;

  logic [CW-1:0]           run_cnt;
  logic [LOAD_LATENCY-1:0] tag_v;
  logic [LOAD_LATENCY-1:0] tag_fetch;
  logic                    fetch_force;
  logic                    push_v;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= BOOT;
      core_run <= 1'b0;
    end else begin
      case (state)
        BOOT: if (boot_done) begin
          state    <= RUN;
          core_run <= 1'b1;
        end
        RUN: begin
          state    <= RUN;
          core_run <= 1'b1;
        end
        default: begin
          state    <= BOOT;
          core_run <= 1'b0;
        end
      endcase
    end
  end

  // Fetch is forced through once data has held the port MAX_DATA_RUN times in a row.
  assign fetch_force = (run_cnt == CW'(MAX_DATA_RUN)) && i_req;
  assign ld_gnt      = (state == BOOT) && ld_req;
  assign d_gnt       = (state == RUN) && d_req && !fetch_force;
  assign i_gnt       = (state == RUN) && i_req && !d_gnt;
  assign push_v      = (d_gnt && (d_we == '0)) || i_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_we    = '1;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_we    = d_we;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt   <= '0;
      tag_v     <= '0;
      tag_fetch <= '0;
    end else begin
      if (i_gnt || !i_req)
        run_cnt <= '0;
      else if (d_gnt && (run_cnt != CW'(MAX_DATA_RUN)))
        run_cnt <= run_cnt + CW'(1);
      tag_v[0]     <= push_v;
      tag_fetch[0] <= i_gnt;
      for (int k = 1; k < LOAD_LATENCY; k++) begin
        tag_v[k]     <= tag_v[k-1];
        tag_fetch[k] <= tag_fetch[k-1];
      end
    end
  end

  assign d_rvalid = tag_v[LOAD_LATENCY-1] && !tag_fetch[LOAD_LATENCY-1];
  assign i_rvalid = tag_v[LOAD_LATENCY-1] &&  tag_fetch[LOAD_LATENCY-1];
  assign d_rdata  = mem_rdata;
  assign i_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a 2-cycle memory model
`ifndef ADDR_W
`define ADDR_W 10
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_req, boot_done, ld_gnt;
  logic [9:0]  ld_addr, d_addr, i_addr, mem_addr;
  logic [31:0] ld_wdata, d_wdata, d_rdata, i_rdata, mem_wdata, mem_rdata;
  logic [3:0]  d_we, mem_we;
  logic        d_req, d_gnt, d_rvalid, i_req, i_gnt, i_rvalid, core_run;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] q0, q1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LOAD_LATENCY(2), .MAX_DATA_RUN(4)) dut (
    .clk(clk), .rstn(rstn),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .boot_done(boot_done), .ld_gnt(ld_gnt),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .core_run(core_run), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Single-port memory with two-cycle read latency.
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 + i;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    q0 <= mem[mem_addr];
    q1 <= q0;
  end
  assign mem_rdata = q1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_req = 0; ld_addr = '0; ld_wdata = '0; boot_done = 0;
    d_req = 0; d_addr = '0; d_wdata = '0; d_we = '0;
    i_req = 0; i_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    tick(); tick();
    ld_req = 1; ld_addr = 10'h3; ld_wdata = 32'h55;
    @(negedge clk);
    total++; if (core_run !== 1'b0) begin bad++; $display("FAIL reset_core_run got=%b exp=0", core_run); end
    total++; if ({d_gnt, i_gnt, d_rvalid, i_rvalid} !== 4'b0) begin bad++; $display("FAIL reset_gnt_rvalid got=%b exp=0000", {d_gnt, i_gnt, d_rvalid, i_rvalid}); end
    total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL reset_ld_gnt got=%b exp=1", ld_gnt); end
    ld_req = 0;
    #1;
    total++; if ({mem_we, mem_addr, mem_wdata} !== 46'b0) begin bad++; $display("FAIL reset_mem_idle got=%h/%h/%h exp=0/0/0", mem_we, mem_addr, mem_wdata); end
    tick();
    rstn = 1;
    tick();
  endtask

  task automatic test_boot();
    i_req = 1; i_addr = 10'h10;
    for (int k = 0; k < 3; k++) begin
      ld_req = 1; ld_addr = 10'(k); ld_wdata = 32'hA0 + k;
      boot_done = (k == 2);
      @(negedge clk);
      total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL boot_ld_gnt%0d got=%b exp=1", k, ld_gnt); end
      total++; if (i_gnt !== 1'b0 || core_run !== 1'b0) begin bad++; $display("FAIL boot_i_gnt%0d got=%b/%b exp=0/0", k, i_gnt, core_run); end
      total++; if (mem_we !== 4'hF || mem_addr !== 10'(k)) begin bad++; $display("FAIL boot_mem%0d got=%h@%h exp=f@%h", k, mem_we, mem_addr, k); end
      tick();
    end
    idle_inputs();
    i_req = 1; i_addr = 10'h10;
    @(negedge clk);
    total++; if (core_run !== 1'b1 || i_gnt !== 1'b1) begin bad++; $display("FAIL boot_release got=%b/%b exp=1/1", core_run, i_gnt); end
    tick();
    i_req = 0;
    tick(); tick(); tick();
    total++; if (mem[2] !== 32'hA2) begin bad++; $display("FAIL boot_mem_written got=%h exp=a2", mem[2]); end
  endtask

  task automatic test_latency();
    i_req = 1; i_addr = 10'h10;
    @(negedge clk);
    total++; if (i_gnt !== 1'b1 || mem_addr !== 10'h10 || mem_we !== 4'h0) begin bad++; $display("FAIL lat_grant got=%b@%h we=%h exp=1@10 we=0", i_gnt, mem_addr, mem_we); end
    tick();
    i_req = 0;
    @(negedge clk);
    total++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL lat_t1 got=%b/%b exp=0/0", i_rvalid, d_rvalid); end
    tick();
    @(negedge clk);
    total++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin bad++; $display("FAIL lat_t2_valid got=%b/%b exp=1/0", i_rvalid, d_rvalid); end
    total++; if (i_rdata !== 32'hC0DE0010) begin bad++; $display("FAIL lat_t2_data got=%h exp=c0de0010", i_rdata); end
    tick();
    @(negedge clk);
    total++; if (i_rvalid !== 1'b0) begin bad++; $display("FAIL lat_t3 got=%b exp=0", i_rvalid); end
    tick();
  endtask

  task automatic test_contention();
    d_req = 1; d_addr = 10'h20; d_we = 4'h0;
    i_req = 1; i_addr = 10'h30;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({d_gnt, i_gnt} !== ((c % 5 == 4) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL contend_c%0d got d/i=%b%b exp=%s", c, d_gnt, i_gnt, (c % 5 == 4) ? "01" : "10");
      end
      tick();
    end
    i_req = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if ({d_gnt, i_gnt} !== 2'b10) begin bad++; $display("FAIL data_only_c%0d got d/i=%b%b exp=10", c, d_gnt, i_gnt); end
      tick();
    end
    d_req = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_store();
    d_req = 1; d_addr = 10'h40; d_we = 4'b0011; d_wdata = 32'h12345678;
    @(negedge clk);
    total++; if (d_gnt !== 1'b1 || mem_we !== 4'b0011 || mem_wdata !== 32'h12345678) begin bad++; $display("FAIL store_issue got=%b we=%h wd=%h exp=1 we=3 wd=12345678", d_gnt, mem_we, mem_wdata); end
    tick();
    d_we = 4'b0000;
    @(negedge clk);
    total++; if (d_gnt !== 1'b1 || mem_we !== 4'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL reload_issue got=%b we=%h rv=%b exp=1 we=0 rv=0", d_gnt, mem_we, d_rvalid); end
    tick();
    d_req = 0;
    @(negedge clk);
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL store_no_rvalid got=%b exp=0", d_rvalid); end
    tick();
    @(negedge clk);
    total++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 32'hC0DE5678) begin bad++; $display("FAIL reload_data got=%b/%b %h exp=1/0 c0de5678", d_rvalid, i_rvalid, d_rdata); end
    tick(); tick();
  endtask

  task automatic test_reset_midflight();
    i_req = 1; i_addr = 10'h11;
    tick();
    i_req = 0; d_req = 1; d_addr = 10'h12; d_we = 4'h0;
    tick();
    d_req = 0; rstn = 0;
    @(negedge clk);
    total++; if (core_run !== 1'b0 || i_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_in_reset got=%b/%b exp=0/0", core_run, i_rvalid); end
    tick();
    rstn = 1; ld_req = 1; ld_addr = 10'h5; ld_wdata = 32'hB5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid_c%0d got=%b/%b exp=0/0", c, d_rvalid, i_rvalid); end
      total++; if (ld_gnt !== 1'b1 || core_run !== 1'b0) begin bad++; $display("FAIL midrst_boot_c%0d got=%b/%b exp=1/0", c, ld_gnt, core_run); end
      tick();
    end
    ld_req = 0;
    @(negedge clk);
    total++; if (ld_gnt !== 1'b0) begin bad++; $display("FAIL midrst_ld_follow got=%b exp=0", ld_gnt); end
    boot_done = 1;
    tick();
    boot_done = 0;
    tick();
  endtask

  task automatic test_run_ignores_loader();
    ld_req = 1; boot_done = 1; ld_addr = 10'h7; ld_wdata = 32'hFF;
    @(negedge clk);
    total++; if (ld_gnt !== 1'b0 || mem_we !== 4'h0 || core_run !== 1'b1) begin bad++; $display("FAIL run_ld got=%b we=%h run=%b exp=0 we=0 run=1", ld_gnt, mem_we, core_run); end
    tick();
    @(negedge clk);
    total++; if (core_run !== 1'b1 || ld_gnt !== 1'b0) begin bad++; $display("FAIL run_stays got=%b/%b exp=1/0", core_run, ld_gnt); end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_boot();
    test_latency();
    test_contention();
    test_store();
    test_reset_midflight();
    test_run_ignores_loader();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
